// File: rtl/sdram_frame_arbiter_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM frame arbiter.
//   t_arb_state   - arbiter state encoding
//   c_page_words  - words per SDRAM page (one burst)
//   c_frame_pages - pages per 640x480 frame
//   t_ch_rec      - per-channel record (row counter, latched restart)
//   first_set()   - lowest set bit index of a channel mask, -1 if none
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACCEPT = 2'd1,
        ST_WAIT_DONE   = 2'd2
    } t_arb_state;

    localparam int c_page_words  = 512;
    localparam int c_frame_pages = (640 * 480) / c_page_words;
    localparam int c_row_w       = $clog2(c_frame_pages);

    typedef struct packed {
        logic [c_row_w-1:0] row;
        logic               restart_pending;
    } t_ch_rec;

    // Index of the lowest set bit (channel masks are at most 8 wide).
    function automatic int first_set(input logic [7:0] vec);
        int idx;
        idx = -1;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_frame_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin picker.
//   req_vec    in  P_WIDTH : request lines
//   last_grant in  P_WIDTH : one-hot grant of the previous winner
//   grant      out P_WIDTH : one-hot winner, searching upward from last_grant+1
module rr_arbiter #(
    parameter int P_WIDTH = 2
) (
    input  logic [P_WIDTH-1:0] req_vec,
    input  logic [P_WIDTH-1:0] last_grant,
    output logic [P_WIDTH-1:0] grant
);

    logic [P_WIDTH-1:0] above_s;
    logic [P_WIDTH-1:0] masked_s;

    // Requests strictly above the last winner win first; otherwise wrap to the lowest request.
    always_comb begin
        above_s  = ~(last_grant | (last_grant - 1'b1));
        masked_s = req_vec & above_s;
        if (|masked_s) begin
            grant = masked_s & (~masked_s + 1'b1);
        end else begin
            grant = req_vec & (~req_vec + 1'b1);
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: round-robin request arbiter and per-channel frame row
// sequencer in front of sdram_controller (s_sdram_clk domain).
// Optional feature macro: SDRAM_ARB_DOUBLE_BUFFER_EN (double-buffered frame banks).
// Ports:
//   s_sdram_clk, i_rst (sync, active-high)
//   i_req[N], i_frame_restart[N]  - channel request levels / row restart pulses
//   i_ctrl_ready                  - controller ready (registered before use)
//   o_rw_en, o_rw, o_addr, o_ba   - controller request (row, then column 0)
//   o_grant[N], o_busy            - in-flight burst owner / burst in flight
//   o_frame_done[N]               - pulse on a channel's last page completion
//   o_err_timeout                 - sticky: controller never accepted a request
module sdram_frame_arbiter
    import sdram_pkg::*;
#(
    parameter int                  P_NUM_CH      = 2,
    parameter logic [P_NUM_CH-1:0] P_CH_DIR      = 2'b10,
    parameter int                  P_FRAME_PAGES = c_frame_pages,
    parameter int                  P_ADDRW       = 13,
    parameter int                  P_BANKW       = 2,
    parameter int                  P_TIMEOUT     = 1023
) (
    input  logic                s_sdram_clk,
    input  logic                i_rst,
    input  logic [P_NUM_CH-1:0] i_req,
    input  logic [P_NUM_CH-1:0] i_frame_restart,
    input  logic                i_ctrl_ready,
    output logic                o_rw_en,
    output logic                o_rw,
    output logic [P_ADDRW-1:0]  o_addr,
    output logic [P_BANKW-1:0]  o_ba,
    output logic [P_NUM_CH-1:0] o_grant,
    output logic                o_busy,
    output logic [P_NUM_CH-1:0] o_frame_done,
    output logic                o_err_timeout
);

    localparam int ROW_W = $clog2(P_FRAME_PAGES);
    localparam int TMO_W = $clog2(P_TIMEOUT + 1);
    localparam int IDX_W = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1;
    localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(P_FRAME_PAGES - 1);
    localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(P_TIMEOUT);
    localparam logic [P_NUM_CH-1:0] GRANT_INIT = P_NUM_CH'(1) << (P_NUM_CH - 1);

    t_arb_state          state_r;
    logic                ready_q_r;
    logic [P_NUM_CH-1:0] last_grant_r;
    logic [IDX_W-1:0]    cur_idx_r;
    logic [ROW_W-1:0]    row_r [P_NUM_CH];
    logic [P_NUM_CH-1:0] restart_pend_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [P_NUM_CH-1:0] pick_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [P_BANKW-1:0]  rd_ba_s;
    logic [P_BANKW-1:0]  wr_ba_s;

    rr_arbiter #(.P_WIDTH(P_NUM_CH)) u_rr (
        .req_vec    (i_req),
        .last_grant (last_grant_r),
        .grant      (pick_s)
    );

    // One-hot winner to channel index.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < P_NUM_CH; i++) begin
            pick_idx_s = pick_idx_s | (pick_s[i] ? IDX_W'(i) : IDX_W'(0));
        end
    end

`ifdef SDRAM_ARB_DOUBLE_BUFFER_EN
    localparam int FIRST_RD = first_set(8'(P_CH_DIR));
    localparam bit HAS_RD   = (FIRST_RD >= 0);

    logic front_r;
    logic swap_pending_r;

    // Readers scan the front bank while writers fill the back bank.
    always_comb begin
        rd_ba_s = P_BANKW'(front_r);
        wr_ba_s = P_BANKW'(~front_r);
    end
`else
    // Single frame buffer: everything lives in bank 0.
    always_comb begin
        rd_ba_s = '0;
        wr_ba_s = '0;
    end
`endif

    // Arbiter FSM, row counters and all registered outputs.
    always_ff @(posedge s_sdram_clk) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            ready_q_r      <= 1'b0;
            last_grant_r   <= GRANT_INIT;
            cur_idx_r      <= '0;
            restart_pend_r <= '0;
            tmo_cnt_r      <= '0;
            o_rw_en        <= 1'b0;
            o_rw           <= 1'b0;
            o_addr         <= '0;
            o_ba           <= '0;
            o_grant        <= '0;
            o_busy         <= 1'b0;
            o_frame_done   <= '0;
            o_err_timeout  <= 1'b0;
            for (int i = 0; i < P_NUM_CH; i++) begin
                row_r[i] <= '0;
            end
`ifdef SDRAM_ARB_DOUBLE_BUFFER_EN
            front_r        <= 1'b0;
            swap_pending_r <= 1'b0;
`endif
        end else begin
            ready_q_r    <= i_ctrl_ready;
            o_frame_done <= '0;

            // Restart of an idle channel is immediate; the in-flight one is deferred to completion.
            for (int i = 0; i < P_NUM_CH; i++) begin
                if (i_frame_restart[i]) begin
                    if ((state_r != ST_IDLE) && (i == int'(cur_idx_r))) begin
                        restart_pend_r[i] <= 1'b1;
                    end else begin
                        row_r[i] <= '0;
                    end
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (ready_q_r && (|i_req)) begin
                        o_grant      <= pick_s;
                        last_grant_r <= pick_s;
                        cur_idx_r    <= pick_idx_s;
                        o_rw         <= P_CH_DIR[pick_idx_s];
                        // A restart arriving with the grant already means row 0.
                        o_addr       <= i_frame_restart[pick_idx_s] ? '0
                                                                    : P_ADDRW'(row_r[pick_idx_s]);
                        o_ba         <= P_CH_DIR[pick_idx_s] ? rd_ba_s : wr_ba_s;
                        o_rw_en      <= 1'b1;
                        o_busy       <= 1'b1;
                        tmo_cnt_r    <= '0;
                        state_r      <= ST_WAIT_ACCEPT;
                    end
                end

                ST_WAIT_ACCEPT: begin
                    if (!ready_q_r) begin
                        o_rw_en <= 1'b0;
                        o_addr  <= '0;
                        state_r <= ST_WAIT_DONE;
                    end else if (tmo_cnt_r == TMO_MAX) begin
                        // Abandon the request; the row is kept so it is reissued later.
                        o_rw_en       <= 1'b0;
                        o_addr        <= '0;
                        o_grant       <= '0;
                        o_busy        <= 1'b0;
                        o_err_timeout <= 1'b1;
                        state_r       <= ST_IDLE;
                        restart_pend_r[cur_idx_r] <= 1'b0;
                        if (restart_pend_r[cur_idx_r] || i_frame_restart[cur_idx_r]) begin
                            row_r[cur_idx_r] <= '0;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    // Burst completes on the rising edge of controller ready.
                    if (i_ctrl_ready && !ready_q_r) begin
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                        state_r <= ST_IDLE;
                        restart_pend_r[cur_idx_r] <= 1'b0;
                        if (restart_pend_r[cur_idx_r] || i_frame_restart[cur_idx_r]) begin
                            row_r[cur_idx_r] <= '0;
                        end else if (row_r[cur_idx_r] == LAST_ROW) begin
                            row_r[cur_idx_r]        <= '0;
                            o_frame_done[cur_idx_r] <= 1'b1;
`ifdef SDRAM_ARB_DOUBLE_BUFFER_EN
                            // Writer wrap arms the swap; the first reader's wrap performs it.
                            if (!P_CH_DIR[cur_idx_r]) begin
                                if (HAS_RD) begin
                                    swap_pending_r <= 1'b1;
                                end else begin
                                    front_r <= ~front_r;
                                end
                            end else if ((int'(cur_idx_r) == FIRST_RD) && swap_pending_r) begin
                                front_r        <= ~front_r;
                                swap_pending_r <= 1'b0;
                            end
`endif
                        end else begin
                            row_r[cur_idx_r] <= row_r[cur_idx_r] + 1'b1;
                        end
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
module tb_sdram_frame_arbiter;

`ifdef SDRAM_ARB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  restart;
    logic        ready;
    logic        rw_en;
    logic        rw;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  fd;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_frame_arbiter dut (
        .s_sdram_clk     (clk),
        .i_rst           (rst),
        .i_req           (req),
        .i_frame_restart (restart),
        .i_ctrl_ready    (ready),
        .o_rw_en         (rw_en),
        .o_rw            (rw),
        .o_addr          (addr),
        .o_ba            (ba),
        .o_grant         (grant),
        .o_busy          (busy),
        .o_frame_done    (fd),
        .o_err_timeout   (err)
    );

    // Controller model for one burst: accept the pending request, stay busy, then complete.
    task automatic serve(input int busy_cyc, input logic [1:0] rst_mask,
                         output logic ok, output logic [1:0] g, output logic [12:0] a,
                         output logic rw_o, output logic [1:0] ba_o, output logic [12:0] a_after,
                         output logic [1:0] g_after, output logic [1:0] fd_o);
        int n;
        ok = 1'b1; g = '0; a = '0; rw_o = 1'b0; ba_o = '0; a_after = '0; g_after = '0; fd_o = '0;
        n = 0;
        while (rw_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rw_en !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        g = grant; a = addr; rw_o = rw; ba_o = ba;
        ready = 1'b0;
        @(negedge clk);
        n = 0;
        while (rw_en !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rw_en !== 1'b0) begin
            ok = 1'b0;
            ready = 1'b1;
            return;
        end
        a_after = addr;
        for (int k = 0; k < busy_cyc; k++) begin
            restart = (k == 0) ? rst_mask : 2'b00;
            @(negedge clk);
        end
        restart = 2'b00;
        ready = 1'b1;
        @(negedge clk);
        fd_o = fd;
        g_after = grant;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; restart = 2'b00; ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rw_en !== 1'b0) begin failures++; $display("FAIL reset_rw_en: got %b expected 0", rw_en); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (addr !== 13'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_busy_err: got %b%b expected 00", busy, err); end
        checks++; if (fd !== 2'b00 || ba !== 2'b00 || rw !== 1'b0) begin failures++; $display("FAIL reset_fd_ba_rw: got %b %b %b expected 00 00 0", fd, ba, rw); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic ok, rwo;
        logic [1:0] g, bao, ga, fdo, eg, eba;
        logic [12:0] a, aa;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve(50, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
            eg  = (i % 2 == 0) ? 2'b01 : 2'b10;
            eba = (DB && (i % 2 == 0)) ? 2'b01 : 2'b00;
            checks++; if (!ok) begin failures++; $display("FAIL rr_handshake[%0d]: got no handshake expected one", i); end
            checks++; if (g !== eg) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, g, eg); end
            checks++; if (a !== 13'(i / 2)) begin failures++; $display("FAIL rr_addr[%0d]: got %0d expected %0d", i, a, i / 2); end
            checks++; if (rwo !== 1'(i % 2)) begin failures++; $display("FAIL rr_rw[%0d]: got %b expected %0d", i, rwo, i % 2); end
            checks++; if (bao !== eba) begin failures++; $display("FAIL rr_ba[%0d]: got %b expected %b", i, bao, eba); end
            checks++; if (aa !== 13'd0) begin failures++; $display("FAIL rr_addr_after[%0d]: got %0d expected 0", i, aa); end
            checks++; if (ga !== 2'b00 || fdo !== 2'b00) begin failures++; $display("FAIL rr_done[%0d]: got grant %b fd %b expected 00 00", i, ga, fdo); end
        end
        req = 2'b00;
    endtask

    task automatic test_frame_wrap();
        logic ok, rwo;
        logic [1:0] g, bao, ga, fdo, efd;
        logic [12:0] a, aa;
        req = 2'b01;
        for (int r = 2; r < 600; r++) begin
            serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
            efd = (r == 599) ? 2'b01 : 2'b00;
            checks++; if (!ok || a !== 13'(r)) begin failures++; $display("FAIL wrap_row: got ok=%b row %0d expected row %0d", ok, a, r); end
            checks++; if (fdo !== efd) begin failures++; $display("FAIL wrap_frame_done at row %0d: got %b expected %b", r, fdo, efd); end
        end
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || a !== 13'd0 || g !== 2'b01) begin failures++; $display("FAIL wrap_row_zero: got ok=%b row %0d grant %b expected row 0 grant 01", ok, a, g); end
        req = 2'b00;
    endtask

    task automatic test_timeout();
        logic ok, rwo;
        logic [1:0] g, bao, ga, fdo;
        logic [12:0] a, aa;
        int n;
        req = 2'b01; ready = 1'b1;
        n = 0;
        while (rw_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rw_en !== 1'b1 || addr !== 13'd1) begin failures++; $display("FAIL tmo_issue: got rw_en %b row %0d expected 1 row 1", rw_en, addr); end
        n = 0;
        while (err !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        checks++; if (n !== 1024) begin failures++; $display("FAIL tmo_latency: got %0d cycles expected 1024", n); end
        checks++; if (rw_en !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL tmo_release: got rw_en %b grant %b busy %b expected 0 00 0", rw_en, grant, busy); end
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || a !== 13'd1) begin failures++; $display("FAIL tmo_reissue: got ok=%b row %0d expected row 1", ok, a); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b expected 1", err); end
        req = 2'b00;
    endtask

    task automatic test_restart();
        logic ok, rwo;
        logic [1:0] g, bao, ga, fdo;
        logic [12:0] a, aa;
        req = 2'b10;
        for (int r = 2; r < 37; r++) begin
            serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
            checks++; if (!ok || a !== 13'(r) || g !== 2'b10) begin failures++; $display("FAIL rst_prep_row: got row %0d grant %b expected row %0d grant 10", a, g, r); end
        end
        serve(3, 2'b10, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || a !== 13'd37) begin failures++; $display("FAIL rst_inflight_row: got %0d expected 37", a); end
        checks++; if (fdo !== 2'b00) begin failures++; $display("FAIL rst_no_frame_done: got %b expected 00", fdo); end
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || a !== 13'd0) begin failures++; $display("FAIL rst_after_row: got %0d expected 0", a); end
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || a !== 13'd1) begin failures++; $display("FAIL rst_resume_row: got %0d expected 1", a); end
        req = 2'b00;
        @(negedge clk);
        restart = 2'b01;
        @(negedge clk);
        restart = 2'b00;
        req = 2'b01;
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || a !== 13'd0 || g !== 2'b01) begin failures++; $display("FAIL rst_idle_row: got row %0d grant %b expected row 0 grant 01", a, g); end
        req = 2'b00;
    endtask

    task automatic test_reset_mid_burst();
        logic ok, rwo;
        logic [1:0] g, bao, ga, fdo;
        logic [12:0] a, aa;
        int n;
        req = 2'b01;
        n = 0;
        while (rw_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rw_en !== 1'b1 || addr !== 13'd1) begin failures++; $display("FAIL mid_issue: got rw_en %b row %0d expected 1 row 1", rw_en, addr); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rw_en !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_out: got rw_en %b grant %b busy %b expected 0 00 0", rw_en, grant, busy); end
        rst = 1'b0;
        req = 2'b11;
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || g !== 2'b01 || a !== 13'd0) begin failures++; $display("FAIL mid_ch0_after: got grant %b row %0d expected 01 row 0", g, a); end
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || g !== 2'b10 || a !== 13'd0) begin failures++; $display("FAIL mid_ch1_after: got grant %b row %0d expected 10 row 0", g, a); end
        req = 2'b00;
    endtask

`ifdef SDRAM_ARB_DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        logic ok, rwo;
        logic [1:0] g, bao, ga, fdo;
        logic [12:0] a, aa;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 2'b01;
        for (int r = 0; r < 600; r++) begin
            serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
            checks++; if (!ok || bao !== 2'b01) begin failures++; $display("FAIL db_write_bank row %0d: got %b expected 01", r, bao); end
        end
        req = 2'b10;
        for (int r = 0; r < 600; r++) begin
            serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
            checks++; if (!ok || bao !== 2'b00) begin failures++; $display("FAIL db_read_bank row %0d: got %b expected 00", r, bao); end
        end
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || bao !== 2'b01) begin failures++; $display("FAIL db_read_swapped: got %b expected 01", bao); end
        req = 2'b01;
        serve(1, 2'b00, ok, g, a, rwo, bao, aa, ga, fdo);
        checks++; if (!ok || bao !== 2'b00) begin failures++; $display("FAIL db_write_swapped: got %b expected 00", bao); end
        req = 2'b00;
    endtask
`endif

    initial begin
        rst = 1'b1; req = 2'b00; restart = 2'b00; ready = 1'b1;
        test_reset();
        test_round_robin();
        test_frame_wrap();
        test_timeout();
        test_restart();
        test_reset_mid_burst();
`ifdef SDRAM_ARB_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
